// File: rtl/rst_seq.sv
// rst_seq: staged reset sequencer.
// Releases STAGE_NUM downstream reset domains one at a time, bit 0 first,
// after the board power-on reset is removed. Each release is followed by a
// wait for that stage's ack and a settling gap before the next release.
// Optional feature macro: RST_SEQ_ACK_EN enables the ack handshake together
// with the ack timeout, the retry/fault paths and the ack-loss restart in DONE.
// Without it the stages are released on a fixed cadence and acks are ignored.
module rst_seq #(
  parameter int MAIN_CLOCK_PERIOD = 7,
  parameter int STAGE_NUM         = 4,
  parameter int STAGE_DELAY       = 1000,
  parameter int ACK_TIMEOUT       = 100000,
  parameter int MAX_RETRY         = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 soft_rst_req,
  input  logic [STAGE_NUM-1:0] stage_ack,
  output logic [STAGE_NUM-1:0] stage_rst_n,
  output logic                 seq_done,
  output logic                 seq_fault,
  output logic [3:0]           retry_cnt
);

  localparam logic [2:0] ST_ASSERT = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_GAP    = 3'd2;
  localparam logic [2:0] ST_RETRY  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;
  localparam logic [2:0] ST_FAULT  = 3'd5;

  // Cycle counts derived from ns values, never below one cycle.
  localparam int          D_RAW  = STAGE_DELAY / MAIN_CLOCK_PERIOD;
  localparam logic [31:0] D_CYC  = (D_RAW < 1) ? 32'd1 : 32'(D_RAW);
  localparam logic [2:0]  LAST_K = 3'(STAGE_NUM - 1);

`ifdef RST_SEQ_ACK_EN
  localparam int          T_RAW       = ACK_TIMEOUT / MAIN_CLOCK_PERIOD;
  localparam logic [31:0] T_CYC       = (T_RAW < 1) ? 32'd1 : 32'(T_RAW);
  localparam logic [3:0]  MAX_RETRY_C = 4'(MAX_RETRY);
  // With a real handshake the gap is the full D cycles after the ack.
  localparam logic [31:0] GAP_END     = D_CYC;
`else
  // The fixed one-cycle WAIT_ACK counts towards the gap so that stages
  // release every D+1 cycles.
  localparam logic [31:0] GAP_END     = D_CYC - 32'd1;
`endif

  logic [2:0]  state_r;
  logic [31:0] cnt_r;
  logic [2:0]  k_r;
  logic [7:0]  rel_r;
  logic        done_r;
  logic        armed_r;
  logic        unused_s;

`ifdef RST_SEQ_ACK_EN
  logic        fault_r;
  logic [3:0]  retry_r;
  logic [7:0]  ack_pad_s;

  // Zero-extend the ack bus so the awaited bit can be picked by stage index.
  always_comb begin
    ack_pad_s                  = 8'd0;
    ack_pad_s[STAGE_NUM-1:0]   = stage_ack;
  end

  assign seq_fault = fault_r;
  assign retry_cnt = retry_r;
  assign unused_s  = ^{rel_r};
`else
  assign seq_fault = 1'b0;
  assign retry_cnt = 4'd0;
  assign unused_s  = ^{rel_r, stage_ack, 32'(ACK_TIMEOUT), 32'(MAX_RETRY)};
`endif

  assign stage_rst_n = rel_r[STAGE_NUM-1:0];
  assign seq_done    = done_r;

  // Sequencer FSM: all outputs are registered here. armed_r delays counting
  // by one edge after power-on reset so the first hold ends on edge D+1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_ASSERT;
      cnt_r   <= 32'd0;
      k_r     <= 3'd0;
      rel_r   <= 8'd0;
      done_r  <= 1'b0;
      armed_r <= 1'b0;
`ifdef RST_SEQ_ACK_EN
      fault_r <= 1'b0;
      retry_r <= 4'd0;
`endif
    end else begin
      armed_r <= 1'b1;
      if (soft_rst_req && (state_r != ST_ASSERT)) begin
        state_r <= ST_ASSERT;
        cnt_r   <= 32'd0;
        k_r     <= 3'd0;
        rel_r   <= 8'd0;
        done_r  <= 1'b0;
`ifdef RST_SEQ_ACK_EN
        fault_r <= 1'b0;
        retry_r <= 4'd0;
`endif
      end else begin
        case (state_r)
          ST_ASSERT: begin
            rel_r <= 8'd0;
            if (cnt_r == D_CYC) begin
              rel_r   <= 8'd1;
              k_r     <= 3'd0;
              cnt_r   <= 32'd0;
              state_r <= ST_WAIT;
            end else if (armed_r) begin
              cnt_r <= cnt_r + 32'd1;
            end
          end
          ST_WAIT: begin
`ifdef RST_SEQ_ACK_EN
            if (ack_pad_s[k_r]) begin
              cnt_r   <= 32'd0;
              state_r <= ST_GAP;
            end else if (cnt_r == (T_CYC - 32'd1)) begin
              cnt_r   <= 32'd0;
              state_r <= ST_RETRY;
            end else begin
              cnt_r <= cnt_r + 32'd1;
            end
`else
            cnt_r   <= 32'd0;
            state_r <= ST_GAP;
`endif
          end
          ST_GAP: begin
            if (cnt_r == GAP_END) begin
              cnt_r <= 32'd0;
              if (k_r == LAST_K) begin
                done_r  <= 1'b1;
                state_r <= ST_DONE;
              end else begin
                rel_r[k_r + 3'd1] <= 1'b1;
                k_r               <= k_r + 3'd1;
                state_r           <= ST_WAIT;
              end
            end else begin
              cnt_r <= cnt_r + 32'd1;
            end
          end
`ifdef RST_SEQ_ACK_EN
          ST_RETRY: begin
            rel_r <= 8'd0;
            cnt_r <= 32'd0;
            if (retry_r == MAX_RETRY_C) begin
              fault_r <= 1'b1;
              state_r <= ST_FAULT;
            end else begin
              retry_r <= retry_r + 4'd1;
              state_r <= ST_ASSERT;
            end
          end
          ST_FAULT: begin
            rel_r <= 8'd0;
          end
`endif
          ST_DONE: begin
`ifdef RST_SEQ_ACK_EN
            if (!(&stage_ack)) begin
              done_r  <= 1'b0;
              retry_r <= 4'd0;
              rel_r   <= 8'd0;
              cnt_r   <= 32'd0;
              state_r <= ST_ASSERT;
            end
`endif
          end
          default: begin
            state_r <= ST_ASSERT;
            cnt_r   <= 32'd0;
            rel_r   <= 8'd0;
            done_r  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: directed bench for rst_seq with D=5, T=20, 3 stages, 2 retries.
// Edge 0 is the first edge that samples rst=1; outputs are sampled 1 time
// unit after each rising edge. The ack-handshake scenarios are built when
// RST_SEQ_ACK_EN is defined, the fixed-cadence scenarios otherwise.
module tb_rst_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       soft_rst_req;
  logic [2:0] stage_ack;
  logic [2:0] stage_rst_n;
  logic       seq_done;
  logic       seq_fault;
  logic [3:0] retry_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int edge_n = 0;

  rst_seq #(
    .MAIN_CLOCK_PERIOD(10),
    .STAGE_NUM        (3),
    .STAGE_DELAY      (50),
    .ACK_TIMEOUT      (200),
    .MAX_RETRY        (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .soft_rst_req(soft_rst_req),
    .stage_ack   (stage_ack),
    .stage_rst_n (stage_rst_n),
    .seq_done    (seq_done),
    .seq_fault   (seq_fault),
    .retry_cnt   (retry_cnt)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic tick_to(input int e);
    while (edge_n < e) tick();
  endtask

  // Pulse soft_rst_req so that it is sampled at edge e.
  task automatic soft_at(input int e);
    tick_to(e - 1);
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
  endtask

  // Two reset edges, check reset values, then release so the next edge is 0.
  task automatic do_reset(input string tag);
    rst          = 1'b0;
    soft_rst_req = 1'b0;
    stage_ack    = 3'b000;
    tick();
    tick();
    chk({tag, "_rst_stage"}, 32'(stage_rst_n), 32'd0);
    chk({tag, "_rst_done"},  32'(seq_done),    32'd0);
    chk({tag, "_rst_fault"}, 32'(seq_fault),   32'd0);
    chk({tag, "_rst_retry"}, 32'(retry_cnt),   32'd0);
    rst    = 1'b1;
    edge_n = -1;
  endtask

  initial begin
    rst          = 1'b0;
    soft_rst_req = 1'b0;
    stage_ack    = 3'b000;

`ifdef RST_SEQ_ACK_EN
    // Normal sequence with acks two cycles after each release, then ack loss.
    do_reset("A");
    tick_to(5);  chk("A_e5",  32'(stage_rst_n), 32'd0);
    tick_to(6);  chk("A_e6",  32'(stage_rst_n), 32'd1);
    tick_to(7);  stage_ack = 3'b001;
    tick_to(13); chk("A_e13", 32'(stage_rst_n), 32'd1);
    tick_to(14); chk("A_e14", 32'(stage_rst_n), 32'd3);
    tick_to(15); stage_ack = 3'b011;
    tick_to(21); chk("A_e21", 32'(stage_rst_n), 32'd3);
    tick_to(22); chk("A_e22", 32'(stage_rst_n), 32'd7);
    tick_to(23); stage_ack = 3'b111;
    tick_to(29); chk("A_done29", 32'(seq_done), 32'd0);
    tick_to(30); chk("A_done30", 32'(seq_done), 32'd1);
    chk("A_retry", 32'(retry_cnt), 32'd0);
    tick_to(32); chk("D_done32", 32'(seq_done), 32'd1);
    stage_ack = 3'b011;
    tick_to(33); chk("D_done33", 32'(seq_done), 32'd0);
    chk("D_stage33", 32'(stage_rst_n), 32'd0);
    tick_to(38); chk("D_e38", 32'(stage_rst_n), 32'd0);
    tick_to(39); chk("D_e39", 32'(stage_rst_n), 32'd1);
    tick_to(46); chk("D_e46", 32'(stage_rst_n), 32'd3);
    soft_at(50); chk("D_soft50", 32'(stage_rst_n), 32'd0);
    tick_to(55); chk("D_e55", 32'(stage_rst_n), 32'd0);
    tick_to(56); chk("D_e56", 32'(stage_rst_n), 32'd1);

    // Stage 1 ack withheld: one retry, then success.
    do_reset("B");
    tick_to(7);  stage_ack = 3'b001;
    tick_to(34); chk("B_e34_stage", 32'(stage_rst_n), 32'd3);
    chk("B_e34_retry", 32'(retry_cnt), 32'd0);
    tick_to(35); chk("B_e35_stage", 32'(stage_rst_n), 32'd0);
    chk("B_e35_retry", 32'(retry_cnt), 32'd1);
    tick_to(40); chk("B_e40", 32'(stage_rst_n), 32'd0);
    tick_to(41); chk("B_e41", 32'(stage_rst_n), 32'd1);
    tick_to(45); stage_ack = 3'b111;
    tick_to(48); chk("B_e48", 32'(stage_rst_n), 32'd3);
    tick_to(54); chk("B_e54", 32'(stage_rst_n), 32'd3);
    tick_to(55); chk("B_e55", 32'(stage_rst_n), 32'd7);
    tick_to(61); chk("B_done61", 32'(seq_done), 32'd0);
    tick_to(62); chk("B_done62", 32'(seq_done), 32'd1);
    chk("B_retry62", 32'(retry_cnt), 32'd1);

    // Stage 0 ack never arrives: three timeouts, fault, soft reset clears it.
    do_reset("C");
    tick_to(27); chk("C_retry27", 32'(retry_cnt), 32'd1);
    tick_to(54); chk("C_retry54", 32'(retry_cnt), 32'd2);
    tick_to(80); chk("C_fault80", 32'(seq_fault), 32'd0);
    chk("C_stage80", 32'(stage_rst_n), 32'd1);
    tick_to(81); chk("C_fault81", 32'(seq_fault), 32'd1);
    chk("C_retry81", 32'(retry_cnt), 32'd2);
    chk("C_stage81", 32'(stage_rst_n), 32'd0);
    tick_to(90); chk("C_fault90", 32'(seq_fault), 32'd1);
    chk("C_stage90", 32'(stage_rst_n), 32'd0);
    soft_at(92); chk("C_soft_fault", 32'(seq_fault), 32'd0);
    chk("C_soft_retry", 32'(retry_cnt), 32'd0);
    tick_to(97); chk("C_e97", 32'(stage_rst_n), 32'd0);
    tick_to(98); chk("C_e98", 32'(stage_rst_n), 32'd1);

    // rst in WAIT_ACK(2); then ack coinciding with timeout; then soft vs ack.
    do_reset("E");
    tick_to(7);  stage_ack = 3'b001;
    tick_to(15); stage_ack = 3'b011;
    tick_to(22); chk("E_e22", 32'(stage_rst_n), 32'd7);
    tick_to(24); rst = 1'b0;
    tick();
    chk("E_rst_stage", 32'(stage_rst_n), 32'd0);
    chk("E_rst_done",  32'(seq_done),    32'd0);
    chk("E_rst_fault", 32'(seq_fault),   32'd0);
    chk("E_rst_retry", 32'(retry_cnt),   32'd0);
    do_reset("F");
    tick_to(25); stage_ack = 3'b001;
    tick_to(26); chk("F_e26", 32'(stage_rst_n), 32'd1);
    tick_to(27); chk("F_e27_stage", 32'(stage_rst_n), 32'd1);
    chk("F_e27_retry", 32'(retry_cnt), 32'd0);
    tick_to(31); chk("F_e31", 32'(stage_rst_n), 32'd1);
    tick_to(32); chk("F_e32", 32'(stage_rst_n), 32'd3);
    stage_ack = 3'b011;
    soft_at(33); chk("F_soft33", 32'(stage_rst_n), 32'd0);
    tick_to(38); chk("F_e38", 32'(stage_rst_n), 32'd0);
    tick_to(39); chk("F_e39", 32'(stage_rst_n), 32'd1);
`else
    // Fixed cadence with stage_ack held low.
    do_reset("N");
    tick_to(5);  chk("N_e5",  32'(stage_rst_n), 32'd0);
    tick_to(6);  chk("N_e6",  32'(stage_rst_n), 32'd1);
    tick_to(11); chk("N_e11", 32'(stage_rst_n), 32'd1);
    tick_to(12); chk("N_e12", 32'(stage_rst_n), 32'd3);
    tick_to(17); chk("N_e17", 32'(stage_rst_n), 32'd3);
    tick_to(18); chk("N_e18", 32'(stage_rst_n), 32'd7);
    tick_to(23); chk("N_done23", 32'(seq_done), 32'd0);
    tick_to(24); chk("N_done24", 32'(seq_done), 32'd1);
    chk("N_fault24", 32'(seq_fault), 32'd0);
    chk("N_retry24", 32'(retry_cnt), 32'd0);
    // Ack activity in DONE must not restart anything.
    stage_ack = 3'b111;
    tick_to(26); stage_ack = 3'b000;
    tick_to(28); chk("N_done28", 32'(seq_done), 32'd1);
    chk("N_stage28", 32'(stage_rst_n), 32'd7);
    soft_at(30); chk("N_soft30_stage", 32'(stage_rst_n), 32'd0);
    chk("N_soft30_done", 32'(seq_done), 32'd0);
    tick_to(35); chk("N_e35", 32'(stage_rst_n), 32'd0);
    tick_to(36); chk("N_e36", 32'(stage_rst_n), 32'd1);
    tick_to(42); chk("N_e42", 32'(stage_rst_n), 32'd3);
    tick_to(44); chk("N_e44", 32'(stage_rst_n), 32'd3);
    soft_at(45); chk("N_soft45", 32'(stage_rst_n), 32'd0);
    tick_to(50); chk("N_e50", 32'(stage_rst_n), 32'd0);
    tick_to(51); chk("N_e51", 32'(stage_rst_n), 32'd1);
    tick_to(53); rst = 1'b0;
    tick();
    chk("N_rst_stage", 32'(stage_rst_n), 32'd0);
    chk("N_rst_done",  32'(seq_done),    32'd0);
    do_reset("M");
    tick_to(5);  chk("M_e5", 32'(stage_rst_n), 32'd0);
    tick_to(6);  chk("M_e6", 32'(stage_rst_n), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rst_seq.md
# rst_seq

Staged reset sequencer that consumes the board power-on reset and releases the downstream reset domains one at a time in a fixed order. Each stage is released, the sequencer waits for that stage's ready/ack, holds a settling gap, and then releases the next stage. It retries the whole sequence on an ack timeout and latches a fault after too many retries. It sits between the power-on reset generator and the DDS/PLL/interface blocks, which must come out of reset in order.

## Interface
- MAIN_CLOCK_PERIOD, 7: clk period in ns.
- STAGE_NUM, 4: number of sequenced reset stages, 1..8.
- STAGE_DELAY, 1000: assert-hold and inter-stage gap, in ns.
- ACK_TIMEOUT, 100000: maximum wait for one stage ack, in ns.
- MAX_RETRY, 3: number of retries allowed before fault, 0..15.

- clk  in  1  main clock.
- rst  in  1  synchronous, active-low reset (the power-on reset output).
- soft_rst_req  in  1  single-cycle request to rerun the full sequence.
- stage_ack  in  STAGE_NUM  per-stage ready, level; already synchronous to clk.
- stage_rst_n  out  STAGE_NUM  per-stage active-low reset; bit 0 is released first.
- seq_done  out  1  all stages released and acked.
- seq_fault  out  1  retries exhausted; sticky.
- retry_cnt  out  4  number of retries taken in the current sequence.

## Operation
- Cycle constants use integer division: D = STAGE_DELAY/MAIN_CLOCK_PERIOD and T = ACK_TIMEOUT/MAIN_CLOCK_PERIOD. Each constant is clamped to a minimum of 1.
- FSM states:
  - ASSERT: all stage_rst_n low. Hold for D cycles, then drive stage_rst_n[0] high, set k=0 and go to WAIT_ACK.
  - WAIT_ACK(k): when stage_ack[k] is sampled 1, go to GAP(k). If T cycles elapse without the ack, go to RETRY.
  - GAP(k): hold for D cycles. If k=STAGE_NUM-1, go to DONE. Otherwise drive stage_rst_n[k+1] high, k++ and go to WAIT_ACK.
  - RETRY (1 cycle): all stage_rst_n low. If retry_cnt==MAX_RETRY, go to FAULT. Otherwise retry_cnt++ and go to ASSERT.
  - DONE: seq_done=1.
  - FAULT: seq_fault=1, all stage_rst_n low.
- Only the ack of the stage currently awaited is used. Acks of unreleased stages are ignored, and acks of already-passed stages are ignored until DONE.
- In DONE, if any stage_ack falls: seq_done clears, retry_cnt clears, and the FSM goes to ASSERT.
- soft_rst_req in any state other than ASSERT: all stage_rst_n low, retry_cnt=0, seq_fault=0, seq_done=0, then go to ASSERT. In ASSERT the request is ignored.
- Counter width is 32 bits. The counter reloads to 0 on every state entry.

## Timing
- While rst=0: state ASSERT with its counter held at 0, stage_rst_n=0, seq_done=0, seq_fault=0, retry_cnt=0.
- All outputs are registered.
- stage_rst_n[0] rises on the (D+1)th edge after the first edge that samples rst=1.
- Ack sampled at edge n: stage_rst_n[k+1] rises at edge n+D+1.
- Ack of the last stage sampled at edge n: seq_done rises at edge n+D+1.
- Timeout: WAIT_ACK entered at edge n with no ack → RETRY at edge n+T, stage_rst_n all low at n+T+1.
- Simultaneous events:
  - Ack and timeout in the same cycle: the ack wins.
  - soft_rst_req and an ack in the same cycle: soft_rst_req wins.
  - rst low and anything else: rst wins.
- rst asserted mid-sequence: all outputs return to their reset values on the next edge.

## Configuration
- RST_SEQ_ACK_EN defined:
  - Behaviour is as described above.
- RST_SEQ_ACK_EN undefined:
  - stage_ack is ignored.
  - WAIT_ACK lasts exactly 1 cycle, then goes to GAP, so stages release every D+1 cycles.
  - No timeout and no RETRY/FAULT paths are generated.
  - seq_fault is tied 0 and retry_cnt is tied 0.
  - The DONE ack-loss restart is removed.

## Test plan
Bench parameters: MAIN_CLOCK_PERIOD=10, STAGE_DELAY=50 (D=5), ACK_TIMEOUT=200 (T=20), STAGE_NUM=3, MAX_RETRY=2.
- Normal sequence, acks 2 cycles after each release: rst released at edge 0 → stage_rst_n[0] rises at edge 6, [1] at 14, [2] at 22, seq_done at 30, retry_cnt=0.
- Stage 1 ack withheld: RETRY occurs 20 cycles after stage 1 release, retry_cnt=1, all stage_rst_n low for D+1 cycles, then the sequence restarts. Providing the ack afterwards → seq_done=1, retry_cnt=1.
- Stage 0 ack never arrives: after 3 timeouts seq_fault=1, retry_cnt=2, stage_rst_n=3'b000 is held. soft_rst_req then clears the fault and restarts the sequence.
- Ack loss and soft reset: stage_ack[2] drops in DONE → seq_done=0 the next cycle, full resequence. soft_rst_req during GAP(1) → stage_rst_n=0 the next cycle, back to ASSERT.
- rst pulled low during WAIT_ACK(2): all outputs reset on the next edge. Ack and timeout arriving in the same cycle: the ack is honoured and no retry is counted.
- Build without RST_SEQ_ACK_EN with stage_ack=0: stages still release at edges 6, 12, 18; seq_done=1 at edge 24; seq_fault stays 0.
